// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
// Size codes, memory-stage FSM states and the execute-to-memory record.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        is_load;
    logic        is_store;
    logic [1:0]  mem_size;
    logic        load_signed;
    logic        wen;
    logic [4:0]  regsrc;
  } ex_mem_t;

  function automatic logic [3:0] store_strb(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] s;
    unique case (1'b1)
      size == SZ_BYTE: s = 4'b0001 << addr;
      size == SZ_HALF: s = addr[1] ? 4'b1100 : 4'b0011;
      default:         s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] w;
    unique case (1'b1)
      size == SZ_BYTE: w = {4{data[7:0]}};
      size == SZ_HALF: w = {2{data[15:0]}};
      default:         w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational; the address low bits pick the byte or half lane.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {addr, 3'b000};
  assign b       = shifted[7:0];
  assign h       = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      size == SZ_BYTE: data = {{24{sign_ext & b[7]}}, b};
      size == SZ_HALF: data = {{16{sign_ext & h[15]}}, h};
      default:         data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: holds one instruction from execute and runs
// the request / addr-ack / data-ack transaction for loads and stores.
module mem_access_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  output logic        mem_allowin,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_store_data,
  input  logic        exe_is_load,
  input  logic        exe_is_store,
  input  logic [1:0]  exe_mem_size,
  input  logic        exe_load_signed,
  input  logic        exe_wen,
  input  logic [4:0]  exe_regsrc,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_valid,
  input  logic        wb_allowin,
  output logic        mem_wen,
  output logic [4:0]  mem_regsrc,
  output logic [31:0] mem_result,
  output logic        mem_fwd_valid,
  output logic [4:0]  mem_fwd_regsrc,
  output logic [31:0] mem_fwd_data,
  output logic        mem_fwd_pending
);

  ex_mem_t     r;
  ex_mem_t     exe_rec;
  logic        r_valid;
  logic [1:0]  state;
  logic [31:0] r_result;
  logic [31:0] load_data;
  logic        done;
  logic        accept;
  logic        retire;

  assign exe_rec = '{
    alu_result:  exe_alu_result,
    store_data:  exe_store_data,
    is_load:     exe_is_load,
    is_store:    exe_is_store,
    mem_size:    exe_mem_size,
    load_signed: exe_load_signed,
    wen:         exe_wen,
    regsrc:      exe_regsrc
  };

  assign done        = (state == ST_IDLE);
  assign mem_valid   = r_valid & done;
  assign mem_allowin = !r_valid | (done & wb_allowin);
  assign accept      = exe_valid & mem_allowin;
  assign retire      = mem_valid & wb_allowin;

  mem_load_align u_align (
    .rdata    (data_rdata),
    .addr     (r.alu_result[1:0]),
    .size     (r.mem_size),
    .sign_ext (r.load_signed),
    .data     (load_data)
  );

  // accept is only possible when done, so it never races the FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r        <= '0;
      r_valid  <= 1'b0;
      state    <= ST_IDLE;
      r_result <= '0;
    end else if (accept) begin
      r       <= exe_rec;
      r_valid <= 1'b1;
      state   <= (exe_is_load | exe_is_store) ? ST_REQ : ST_IDLE;
    end else begin
      if (retire)
        r_valid <= 1'b0;
      unique case (state)
        ST_REQ:
          if (data_addr_ok)
            state <= ST_WAIT;
        ST_WAIT:
          if (data_data_ok) begin
            if (r.is_load)
              r_result <= load_data;
            state <= ST_IDLE;
          end
        default: ;
      endcase
    end
  end

  assign data_req   = (state == ST_REQ);
  assign data_wr    = r.is_store;
  assign data_addr  = r.alu_result;
  assign data_wstrb = r.is_store
                    ? store_strb(r.mem_size, r.alu_result[1:0])
                    : 4'b0000;
  assign data_wdata = store_lanes(r.mem_size, r.store_data);

  assign mem_wen         = r.wen & !r.is_store;
  assign mem_regsrc      = r.regsrc;
  assign mem_result      = r.is_load ? r_result : r.alu_result;
  assign mem_fwd_valid   = r_valid & mem_wen & (r.regsrc != 5'd0);
  assign mem_fwd_regsrc  = r.regsrc;
  assign mem_fwd_data    = mem_result;
  assign mem_fwd_pending = r_valid & r.is_load & !done;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage MIPS pipeline. It sits between the execute stage and write-back and accepts one instruction at a time from execute over a valid/allowin handshake. For loads and stores it runs a request/address-ack/data-ack transaction on the data-memory port; for all other instructions it passes the ALU result through. It presents the write-back record and the forwarding and load-pending information that the execute stage and the hazard logic consume.

## Interface
- No parameters. Data and address widths are fixed at 32 bits and the register index at 5 bits.
- Clock and reset:
  - clk  in  1  rising-edge clock
  - resetn  in  1  asynchronous active-low reset
- Execute-stage inputs:
  - exe_valid  in  1  execute holds a valid instruction
  - mem_allowin  out  1  this stage accepts an instruction this cycle
  - exe_alu_result  in  32  ALU result or effective address
  - exe_store_data  in  32  rt value for stores
  - exe_is_load, exe_is_store  in  1 each  memory operation type
  - exe_mem_size  in  2  size: 00 byte, 01 half, 10 word
  - exe_load_signed  in  1  sign-extend sub-word loads
  - exe_wen  in  1  write-back enable
  - exe_regsrc  in  5  destination register
- Data-memory port:
  - data_req  out  1  request
  - data_wr  out  1  write
  - data_addr  out  32  address
  - data_wstrb  out  4  byte strobes
  - data_wdata  out  32  write data
  - data_addr_ok  in  1  request accepted
  - data_data_ok  in  1  read data valid or write acknowledged
  - data_rdata  in  32  read data
- Write-back side:
  - mem_valid  out  1  record valid
  - wb_allowin  in  1  write-back accepts
  - mem_wen  out  1  write-back enable
  - mem_regsrc  out  5  destination register
  - mem_result  out  32  write-back data
- Forwarding:
  - mem_fwd_valid  out  1  stage will write a nonzero register
  - mem_fwd_regsrc  out  5  destination register
  - mem_fwd_data  out  32  forwarded value
  - mem_fwd_pending  out  1  load data not yet returned; consumers must stall

## Operation
- Holding register r_* captures all exe_* fields, plus r_valid. FSM states: IDLE, REQ, WAIT.
- done = (state==IDLE).
- mem_valid = r_valid & done.
- mem_allowin = !r_valid | (done & wb_allowin).
- Accept occurs on exe_valid & mem_allowin:
  - The instruction is latched into r_*.
  - If it is a load or store, next state is REQ; otherwise it stays IDLE.
- If an instruction retires (mem_valid & wb_allowin) and none is accepted in the same cycle, r_valid clears.
- REQ:
  - data_req=1. Address, wr, wstrb and wdata are held stable.
  - On data_addr_ok, go to WAIT.
- WAIT:
  - data_req=0.
  - On data_data_ok, latch the aligned load data (loads only) into r_result, then go to IDLE.
- data_data_ok is sampled only in WAIT; it is ignored in IDLE and REQ. The responder never returns data_ok in the same cycle as addr_ok.
- data_addr is the full r_alu_result. Misaligned accesses are not trapped; the address is forced by size: half uses addr[1], word ignores addr[1:0].
- Store strobes:
  - byte: 0001 shifted left by addr[1:0], wdata = 4 copies of data[7:0]
  - half: 0011 or 1100 selected by addr[1], wdata = 2 copies of data[15:0]
  - word: 1111, wdata = full word
- Load extraction selects the lane by address, then sign- or zero-extends per r_load_signed.
- mem_result:
  - loads: loaded data
  - stores: alu result
  - other instructions: alu result
- mem_wen = r_wen & !r_is_store.
- mem_fwd_valid = r_valid & mem_wen & (r_regsrc != 0).
- mem_fwd_data = mem_result.
- mem_fwd_pending = r_valid & r_is_load & !done.

## Timing
- Reset: all outputs 0, state IDLE, r_valid 0. Reset is asynchronous and takes effect immediately, including mid-transaction. An outstanding data_ok arriving after reset release lands in IDLE and is ignored.
- Non-memory instruction: accepted at edge N, mem_valid at N. Latency 1 cycle.
- Load/store:
  - data_req rises in the cycle after accept.
  - Minimum latency is 3 cycles: REQ, WAIT, then IDLE.
- Back-to-back: a retire and an accept in the same cycle are legal; throughput is 1 per cycle for non-memory instructions.
- Backpressure: with wb_allowin=0, every output holds and mem_allowin=0.

## Structure
- Shared package (mips_pkg) holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
- One sub-module, mem_load_align: combinational lane select and extension, with inputs rdata, addr[1:0], size, signed.

## Test plan
- ALU instruction with result 0x12345678, wen=1, regsrc=8, wb_allowin=1 -> next cycle mem_valid=1, mem_result=0x12345678, mem_fwd_valid=1; data_req never asserted.
- lw at 0x100 with addr_ok delayed 2 cycles and data_ok 3 cycles later, rdata=0xDEADBEEF -> data_req high 3 cycles with stable address; mem_fwd_pending=1 and mem_allowin=0 until data_ok; mem_result=0xDEADBEEF.
- Sub-word loads:
  - lb at 0x103, rdata=0x80000000 -> 0xFFFFFF80
  - lbu, same access -> 0x00000080
  - lh at 0x102, rdata=0x80010000 -> 0xFFFF8001
- sb at 0x201 with data 0xAB -> data_wr=1, wstrb=0010, wdata=0xABABABAB, mem_wen=0.
- wb_allowin=0 for 4 cycles with exe_valid=1 -> record held, no accept; on release, retire and accept happen in the same cycle.
- resetn asserted in WAIT -> all outputs 0 immediately; a later data_ok produces no mem_valid.
